// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // Operation encoding matches the RV32M funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // One radix-2 step per cycle, one step per operand bit.
  localparam int MD_ITERS = 32;

  // Every divide/remainder encoding has funct3[2] set.
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes and special-case detection
// at accept, and result negation/selection at finish.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  output logic              special,
  output logic [XLEN-1:0]   special_res,
  input  muldiv_op_e        res_op,
  input  logic [2*XLEN-1:0] res_acc,
  input  logic              res_a_neg,
  input  logic              res_b_neg,
  output logic [XLEN-1:0]   result
);

  logic            a_signed;
  logic            b_signed;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] min_neg;

  assign min_neg = {1'b1, {(XLEN-1){1'b0}}};

  // Accept side: signedness per op, magnitudes, and the RISC-V no-trap special results.
  always_comb begin
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    special_res = '0;
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MD_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = is_div(op) && (op_b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (op_a == min_neg) && (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = ((op == MD_DIV) || (op == MD_DIVU)) ? '1 : op_a;
    end else if (div_ovf) begin
      special_res = (op == MD_DIV) ? min_neg : '0;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Finish side: restore signs on the raw accumulator and pick the requested half.
  always_comb begin
    prod   = (res_a_neg ^ res_b_neg) ? -res_acc : res_acc;
    quo    = res_acc[XLEN-1:0];
    rem    = res_acc[2*XLEN-1:XLEN];
    result = '0;
    case (res_op)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV:                       result = (res_a_neg ^ res_b_neg) ? -quo : quo;
      MD_DIVU:                      result = quo;
      MD_REM:                       result = res_a_neg ? -rem : rem;
      MD_REMU:                      result = rem;
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/busy handshake, 32-cycle
// radix-2 shift-add / restoring-divide datapath, single-cycle writeback pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("muldiv_unit supports only XLEN=32");
    end
  endgenerate

  muldiv_state_e     state;
  muldiv_state_e     state_next;
  muldiv_op_e        op_e;
  muldiv_op_e        op_q;
  logic [4:0]        rd_q;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              special_q;
  logic              accept;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              a_neg;
  logic              b_neg;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   result;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;

  assign op_e   = muldiv_op_e'(op);
  assign accept = (state == IDLE) && start && !flush;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op          (op_e),
    .op_a        (op_a),
    .op_b        (op_b),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .a_neg       (a_neg),
    .b_neg       (b_neg),
    .special     (special),
    .special_res (special_res),
    .res_op      (op_q),
    .res_acc     (acc),
    .res_a_neg   (a_neg_q),
    .res_b_neg   (b_neg_q),
    .result      (result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = special ? DONE : CALC;
      CALC: if (cnt == 5'(MD_ITERS - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // One datapath step: multiply adds into the high half and shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    acc_step = acc;
    if (is_div(op_q)) begin
      if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_step = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {mul_sum, acc[XLEN-1:1]};
      else        acc_step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Operand latch at accept and iteration in CALC; special results park in the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MD_MUL;
      rd_q      <= '0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      special_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op_e;
      rd_q      <= rd_in;
      cnt       <= '0;
      a_neg_q   <= a_neg;
      b_neg_q   <= b_neg;
      special_q <= special;
      if (special) begin
        acc  <= {{XLEN{1'b0}}, special_res};
        opnd <= '0;
      end else if (is_div(op_e)) begin
        acc  <= {{XLEN{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if ((state == CALC) && !flush) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
    end
  end

  // Registered handshake and writeback; the pulse follows the DONE state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      busy  <= (state_next != IDLE);
      wb_we <= (state == DONE) && !flush;
      if ((state == DONE) && !flush) begin
        wb_rd   <= rd_q;
        wb_data <= special_q ? acc[XLEN-1:0] : result;
      end
    end
  end

endmodule
